// File: rtl/irq_pending_arbiter.sv
// Purpose: turns edges on eight async irq lines into sticky pending bits and presents the top unmasked one.
// Latency: irq_in edge to irq_valid is SYNC_STAGES+2 edges; next ID follows an accept by 2 edges.
// Backpressure: a presented ID is held stable until irq_ready; new edges keep accumulating as pending/ovf.

// Priority encoder: index of the highest set bit; only meaningful when req != 0.
module priority_encoder_8to3 (
    input  logic [7:0] req,
    output logic [2:0] idx
);
    // Scan upward so the highest set bit is the last to assign idx.
    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) idx = 3'(i);
        end
    end
endmodule

module irq_pending_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic [7:0] irq_mask,
    input  logic       irq_ready,
    input  logic [7:0] ovf_clr,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] irq_pending,
    output logic [7:0] irq_ovf
);
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state_q, state_nxt;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] dly_q;
    logic [7:0] rise;
    logic [7:0] pending_q;
    logic [7:0] ovf_q;
    logic [7:0] req;
    logic [7:0] clr_vec;
    logic [2:0] enc_idx;
    logic [2:0] id_q;
    logic       accept;
    logic       id_load;

    // Synchroniser chain; sync_q[SYNC_STAGES-1] is the clean line value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Delay flop for edge detection; resetting to 0 makes a line held high through reset count as one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_q <= '0;
        else        dly_q <= sync_q[SYNC_STAGES-1];
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign accept  = (state_q == PRESENT) && irq_ready;
    assign clr_vec = accept ? (8'b1 << id_q) : 8'b0;
    assign req     = pending_q & ~irq_mask;

    // Pending and overflow: a new edge beats both the accept-clear and the software clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_vec) | rise;
            ovf_q     <= (ovf_q & ~ovf_clr) | (rise & pending_q & ~clr_vec);
        end
    end

    priority_encoder_8to3 u_enc (
        .req (req),
        .idx (enc_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Next state: latch a winner from IDLE, hold it in PRESENT until accepted.
    always_comb begin
        state_nxt = state_q;
        id_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 8'b0) begin
                    id_load   = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Presented ID; only loaded on the IDLE->PRESENT transition so it never changes under the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       id_q <= '0;
        else if (id_load) id_q <= enc_idx;
    end

    assign irq_valid   = (state_q == PRESENT);
    assign irq_id      = id_q;
    assign irq_pending = pending_q;
    assign irq_ovf     = ovf_q;
endmodule

// File: tb/tb_irq_pending_arbiter.sv
module tb_irq_pending_arbiter;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] irq_mask;
    logic       irq_ready;
    logic [7:0] ovf_clr;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] irq_pending;
    logic [7:0] irq_ovf;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: history of sampled lines (newest first), pending/ovf sets,
    // and the presented line number (-1 when nothing is presented).
    logic [7:0] hist[$];
    logic [7:0] m_pend;
    logic [7:0] m_ovf;
    int         m_pres;
    logic [2:0] m_id;

    always #5 clk = ~clk;

    irq_pending_arbiter #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .irq_ready   (irq_ready),
        .ovf_clr     (ovf_clr),
        .irq_valid   (irq_valid),
        .irq_id      (irq_id),
        .irq_pending (irq_pending),
        .irq_ovf     (irq_ovf)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back(8'h00);
        m_pend = 8'h00;
        m_ovf  = 8'h00;
        m_pres = -1;
        m_id   = 3'd0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_valid"},   {7'b0, irq_valid}, {7'b0, (m_pres >= 0)});
        check({tag, "_id"},      {5'b0, irq_id},    {5'b0, m_id});
        check({tag, "_pending"}, irq_pending,       m_pend);
        check({tag, "_ovf"},     irq_ovf,           m_ovf);
    endtask

    // One clock edge: predict from the inputs present at the edge, then compare just after it.
    task automatic step(input string tag);
        logic [7:0] rise, clr, req, pn, on, samp;
        int         pr;
        logic [2:0] idn;
        rise = 8'h00; clr = 8'h00; pn = m_pend; on = m_ovf; samp = 8'h00;
        pr = m_pres; idn = m_id;
        if (rst_n) begin
            // A line edge is seen once it has crossed SYNC sample times and was low the sample before.
            rise = hist[SYNC-1] & ~hist[SYNC];
            if (m_pres >= 0 && irq_ready) clr = 8'(1 << m_pres);
            pn = (m_pend & ~clr) | rise;
            on = (m_ovf & ~ovf_clr) | (rise & m_pend & ~clr);
            if (m_pres >= 0) begin
                if (irq_ready) pr = -1;
            end else begin
                req = m_pend & ~irq_mask;
                for (int i = 0; i < 8; i++) begin
                    if (req[i]) begin
                        pr  = i;
                        idn = 3'(i);
                    end
                end
            end
            samp = irq_in;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            hist.push_front(samp);
            void'(hist.pop_back());
            m_pend = pn;
            m_ovf  = on;
            m_pres = pr;
            m_id   = idn;
        end
        check_all(tag);
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Drop reset mid-cycle and check outputs clear without any clock edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; irq_in = 8'h00; irq_mask = 8'h00; irq_ready = 1'b1; ovf_clr = 8'h00;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Single line
        irq_in = 8'h01; step("single");
        irq_in = 8'h00; steps("single", 3);
        check("single_valid_e4", {7'b0, irq_valid}, 8'h01);
        check("single_id_e4", {5'b0, irq_id}, 8'h00);
        step("single_acc");
        check("single_pend_after", irq_pending, 8'h00);
        check("single_valid_after", {7'b0, irq_valid}, 8'h00);
        steps("single_idle", 2);

        // Priority order 7,5,3
        irq_in = 8'hA8; step("prio");
        irq_in = 8'h00; steps("prio", 2);
        check("prio_pend0", irq_pending, 8'hA8);
        step("prio");
        check("prio_id7", {5'b0, irq_id}, 8'h07);
        step("prio");
        check("prio_pend1", irq_pending, 8'h28);
        steps("prio", 4);
        check("prio_pend3", irq_pending, 8'h00);
        steps("prio", 2);

        // Hold under backpressure
        irq_ready = 1'b0;
        irq_in = 8'h08; step("hold");
        irq_in = 8'h00; steps("hold", 3);
        irq_in = 8'h40; step("hold");
        irq_in = 8'h00; steps("hold", 5);
        check("hold_id3", {5'b0, irq_id}, 8'h03);
        check("hold_valid", {7'b0, irq_valid}, 8'h01);
        irq_ready = 1'b1; step("hold_acc");
        steps("hold_next", 1);
        check("hold_id6", {5'b0, irq_id}, 8'h06);
        steps("hold_drain", 3);

        // Mask
        irq_mask = 8'h80;
        irq_in = 8'h80; step("mask");
        irq_in = 8'h00; steps("mask", 5);
        check("mask_pend", irq_pending, 8'h80);
        check("mask_valid", {7'b0, irq_valid}, 8'h00);
        irq_mask = 8'h00; steps("unmask", 4);

        // Overflow
        irq_ready = 1'b0;
        irq_in = 8'h04; step("ovf");
        irq_in = 8'h00; steps("ovf", 9);
        irq_in = 8'h04; step("ovf");
        irq_in = 8'h00; steps("ovf", 4);
        check("ovf_set", irq_ovf, 8'h04);
        irq_in = 8'h04; step("ovf_race");
        irq_in = 8'h00; step("ovf_race");
        ovf_clr = 8'h04; step("ovf_race");
        ovf_clr = 8'h00;
        check("ovf_race", irq_ovf, 8'h04);
        ovf_clr = 8'h04; step("ovf_clr");
        ovf_clr = 8'h00;
        check("ovf_clr", irq_ovf, 8'h00);
        irq_in = 8'h04; step("acc_rise");
        irq_in = 8'h00; step("acc_rise");
        irq_ready = 1'b1; step("acc_rise");
        check("acc_rise_ovf", irq_ovf, 8'h00);
        check("acc_rise_pend", irq_pending, 8'h04);
        steps("acc_rise", 4);

        // Reset with a line held high
        irq_in = 8'h10; irq_ready = 1'b0;
        async_reset("rst_hold");
        steps("rst_low", 2);
        rst_n = 1'b1;
        steps("rst_rel", 5);
        check("rst_id4", {5'b0, irq_id}, 8'h04);
        async_reset("rst_mid");
        rst_n = 1'b1;
        irq_in = 8'h00;
        steps("rst_after", 4);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            irq_in    = 8'($urandom) & 8'($urandom) & 8'($urandom);
            irq_mask  = 8'($urandom) & 8'($urandom);
            irq_ready = 1'($urandom_range(0, 1));
            ovf_clr   = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rand_rst");
                #2 rst_n = 1'b1;
            end
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
